// File: rtl/data_sram_pkg.sv
// Shared types and constants for the data-SRAM responder.
// Encodings, tracking-entry layout and the LFSR tap mask.
package data_sram_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam int CD_W = 8;

   // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic            is_write;
      logic [31:0]     word;
      logic [CD_W-1:0] countdown;
   } resp_entry_t;

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order completion tracker: circular FIFO whose entries all
// count down their remaining latency every cycle.
module resp_fifo
   import data_sram_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  resp_entry_t      push_entry,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output resp_entry_t      head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   resp_entry_t   slots [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push && wr_ptr == PW'(i))
            slots[i] <= push_entry;
         else if (slots[i].countdown != '0)
            slots[i].countdown <= slots[i].countdown - 1'b1;
      end
   end

   assign head  = slots[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word RAM with in-order, fixed-latency completions.
// Define DATA_SRAM_RANDOM_DELAY_EN for LFSR-driven accept/complete stalls.
module data_sram_responder
   import data_sram_pkg::*;
#(
   parameter int          MEM_WORDS_LOG2 = 12,
   parameter int          LATENCY        = 2,
   parameter int          OUTSTANDING    = 2,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [3:0]  wstrb,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int CNT_W = $clog2(OUTSTANDING + 1);

   logic [31:0] mem [2**MEM_WORDS_LOG2];

   logic [MEM_WORDS_LOG2-1:0] idx;
   logic                      accept;
   logic                      is_wr;
   logic                      fifo_empty;
   logic                      head_ready;
   logic                      stall_acc;
   logic                      stall_pop;
   logic [CNT_W-1:0]          count;
   resp_entry_t               push_entry;
   resp_entry_t               head;

   logic unused_bits;
   assign unused_bits = ^{size, addr[31:MEM_WORDS_LOG2+2], addr[1:0]};

`ifdef DATA_SRAM_RANDOM_DELAY_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   assign stall_acc = lfsr[0];
   assign stall_pop = lfsr[1];
`else
   localparam logic [15:0] unused_seed = LFSR_SEED;
   assign stall_acc = 1'b0;
   assign stall_pop = 1'b0;
`endif

   assign idx     = addr[MEM_WORDS_LOG2+1:2];
   assign is_wr   = |wstrb;
   assign addr_ok = ~rst & (count < CNT_W'(OUTSTANDING)) & ~stall_acc;
   assign accept  = req & addr_ok;

   assign head_ready = ~fifo_empty & (head.countdown == '0);
   assign data_ok    = ~rst & head_ready & ~stall_pop;
   assign rdata      = (data_ok & ~head.is_write) ? head.word : '0;

   // Read word is captured before this edge's write lands.
   always_comb begin
      push_entry           = '0;
      push_entry.is_write  = is_wr;
      push_entry.word      = mem[idx];
      push_entry.countdown = CD_W'(LATENCY - 1);
   end

   always_ff @(posedge clk) begin
      if (accept && is_wr) begin
         for (int i = 0; i < 4; i++)
            if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   resp_fifo #(
      .DEPTH (OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (accept),
      .push_entry (push_entry),
      .pop        (data_ok),
      .count      (count),
      .empty      (fifo_empty),
      .head       (head)
   );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed vector table plus scoreboard sequences for data_sram_responder.
module tb_data_sram_responder;

   localparam int LAT = 2;
   localparam int OUT = 2;

`ifdef DATA_SRAM_RANDOM_DELAY_EN
   localparam int NRAND = 2000;
`else
   localparam int NRAND = 300;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [3:0]  wstrb = '0;
   logic [1:0]  size = 2'b10;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   data_sram_responder #(
      .MEM_WORDS_LOG2 (12),
      .LATENCY        (LAT),
      .OUTSTANDING    (OUT),
      .LFSR_SEED      (16'hACE1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wstrb   (wstrb),
      .size    (size),
      .addr    (addr),
      .wdata   (wdata),
      .addr_ok (addr_ok),
      .data_ok (data_ok),
      .rdata   (rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        e_ok;
      logic        e_dok;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t        tbl [20];
   int          total = 0;
   int          passed = 0;
   int          ndok = 0;
   logic        last_acc;
   logic [31:0] shadow [8];
   logic [31:0] expq [$];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // One cycle with scoreboard: sample at negedge, then step past posedge.
   task automatic cyc();
      int k;
      @(negedge clk);
      if (addr_ok)
         check("addr_ok_bound", 32'(expq.size() < OUT), 32'd1);
      if (data_ok) begin
         ndok++;
         if (expq.size() == 0) check("spurious_data_ok", 32'd1, 32'd0);
         else check("sb_rdata", rdata, expq.pop_front());
      end
      last_acc = req & addr_ok;
      if (last_acc) begin
         k = int'(addr[4:2]);
         if (wstrb != 4'h0) begin
            for (int i = 0; i < 4; i++)
               if (wstrb[i]) shadow[k][8*i +: 8] = wdata[8*i +: 8];
            expq.push_back(32'h0);
         end else begin
            expq.push_back(shadow[k]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic xact(input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d);
      int guard = 0;
      req = 1'b1; wstrb = s; addr = a; wdata = d;
      do begin
         cyc();
         guard++;
      end while (!last_acc && guard < 50);
      if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
      req = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      req = 1'b0;
      while (expq.size() > 0 && guard < 50) begin
         cyc();
         guard++;
      end
      check("drain_left", 32'(expq.size()), 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int acc_n;
      int guard;
      int base;
      int k;
      logic [3:0]  s;
      logic [31:0] r;

      tbl[0]  = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0};
      tbl[3]  = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF};
      tbl[4]  = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
      tbl[5]  = '{1'b1, 4'hF, 32'h14, 32'h11223344, 1'b1, 1'b0, 32'h0};
      tbl[6]  = '{1'b1, 4'h2, 32'h14, 32'hABABABAB, 1'b1, 1'b0, 32'h0};
      tbl[7]  = '{1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b1, 32'h0};
      tbl[8]  = '{1'b1, 4'h0, 32'h14, 32'h0, 1'b1, 1'b1, 32'h0};
      tbl[9]  = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1122AB44};
      tbl[11] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
      tbl[12] = '{1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0};
      tbl[13] = '{1'b1, 4'h0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0};
      tbl[14] = '{1'b1, 4'h0, 32'hFFFF4010, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
      tbl[15] = '{1'b1, 4'h0, 32'hFFFF4010, 32'h0, 1'b1, 1'b1, 32'h1122AB44};
      tbl[16] = '{1'b1, 4'h0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0};
      tbl[17] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
      tbl[18] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1122AB44};
      tbl[19] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_addr_ok", 32'(addr_ok), 32'd0);
      check("rst_data_ok", 32'(data_ok), 32'd0);
      check("rst_rdata", rdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

`ifndef DATA_SRAM_RANDOM_DELAY_EN
      for (int i = 0; i < 20; i++) begin
         req = tbl[i].req; wstrb = tbl[i].wstrb;
         addr = tbl[i].addr; wdata = tbl[i].wdata;
         @(negedge clk);
         check($sformatf("v%0d_addr_ok", i), 32'(addr_ok), 32'(tbl[i].e_ok));
         check($sformatf("v%0d_data_ok", i), 32'(data_ok), 32'(tbl[i].e_dok));
         check($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rdata);
         @(posedge clk);
         #1;
      end
`endif

      // Two reads in flight, then a one-cycle reset drops them.
      req = 1'b1; wstrb = 4'h0; addr = 32'h10;
      @(posedge clk);
      #1;
      addr = 32'h14;
      @(posedge clk);
      #1;
      req = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("mid_rst_addr_ok", 32'(addr_ok), 32'd0);
      check("mid_rst_data_ok", 32'(data_ok), 32'd0);
      check("mid_rst_rdata", rdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
`ifndef DATA_SRAM_RANDOM_DELAY_EN
         if (c == 0) check("post_rst_addr_ok", 32'(addr_ok), 32'd1);
`endif
         check("post_rst_no_data_ok", 32'(data_ok), 32'd0);
         @(posedge clk);
         #1;
      end

      for (int i = 0; i < 8; i++)
         xact(4'hF, 32'(i << 2), 32'hC0DE0000 | 32'(i * 32'h111));
      drain();

      // Back-to-back reads: accepts coincide with pops.
      base = ndok;
      acc_n = 0;
      guard = 0;
      req = 1'b1; wstrb = 4'h0;
      while (acc_n < 20 && guard < 200) begin
         addr = (acc_n % 2 == 1) ? 32'h14 : 32'h10;
         cyc();
         if (last_acc) acc_n++;
         guard++;
      end
      check("b2b_accepts", 32'(acc_n), 32'd20);
      drain();
      check("b2b_data_ok_count", 32'(ndok - base), 32'd20);

      // Random mixed traffic against the scoreboard.
      base = ndok;
      for (int n = 0; n < NRAND; n++) begin
         r = $urandom();
         k = int'($urandom_range(0, 7));
         s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         xact(s, (r & 32'hFFFFC000) | 32'(k << 2), $urandom());
         repeat ($urandom_range(0, 1)) cyc();
      end
      drain();
      check("rand_data_ok_count", 32'(ndok - base), 32'(NRAND));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
Responder (slave) end of the data-SRAM request/addr_ok/data_ok interface driven by the MEM stage. Accepts read/write requests with addr_ok, performs them on an internal word-organised RAM, and returns completions in order via a one-cycle data_ok pulse with a configurable latency. Serves as the data-memory model in the SoC top and as the stall-behaviour stress target for pipeline verification.

Parameters:
MEM_WORDS_LOG2, 12, log2 of RAM depth in 32-bit words
LATENCY, 2, minimum cycles from accept edge to data_ok (>=1)
OUTSTANDING, 2, maximum accepted-but-not-completed transactions (>=1)
LFSR_SEED, 16'hACE1, seed for the optional random-delay LFSR

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
req  in  1  request valid (MEM write_en)
wstrb  in  4  byte write strobes; nonzero = write, zero = read
size  in  2  00 byte, 01 half, 10 word
addr  in  32  byte address
wdata  in  32  write data, already lane-replicated by initiator
addr_ok  out  1  request accepted this cycle when req & addr_ok
data_ok  out  1  one-cycle completion pulse for the oldest accepted transaction
rdata  out  32  full read word; valid only while data_ok on a read

Behaviour:
- Reset: while rst is high, addr_ok=0, data_ok=0, rdata=0; tracking FIFO emptied, counters cleared. RAM contents not reset. Transactions in flight at reset are dropped; no data_ok for them afterwards.
- Accept: addr_ok = ~rst & (count < OUTSTANDING); depends only on registered state, never combinationally on req. Handshake = req & addr_ok at posedge.
- Word index = addr[MEM_WORDS_LOG2+1:2]; upper bits ignored. size is recorded only; alignment is not checked (ALE filtered upstream).
- Writes: applied at the accept edge, byte lane i written iff wstrb[i]. A read accepted on a later edge sees the new data.
- Reads: word sampled at the accept edge into the tracking entry; returned word unmodified (initiator extracts bytes).
- Tracking FIFO entry: {is_write, rdata_word, countdown}. countdown loaded with LATENCY-1 and decremented each cycle while >0 (every entry counts, not only the head).
- Completion: data_ok=1 in a cycle when the FIFO is non-empty and the head countdown==0; head pops at that edge. rdata = head word if the head is a read, else 0. Completion order = acceptance order; data_ok for entry i occurs at max(t_accept_i + LATENCY, previous data_ok + 1).
- Stores also complete with data_ok (rdata=0).
- Simultaneous accept and pop: both happen, count unchanged; full FIFO with a pop in the same cycle does not accept (addr_ok already low).
- Empty: data_ok=0, rdata=0. Pointers wrap modulo OUTSTANDING; count width clog2(OUTSTANDING+1).

Optional Feature:
Macro DATA_SRAM_RANDOM_DELAY_EN. When defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with LFSR_SEED on reset, advances every cycle. addr_ok is additionally masked when lfsr[0]=1; a head ready for completion is held one extra cycle when lfsr[1]=1. Ordering and data semantics are unchanged. When undefined: no LFSR logic; timing is exactly as in Behaviour.

Decomposition:
- Shared package data_sram_pkg: SIZE_B/SIZE_H/SIZE_W encodings, resp_entry_t struct {is_write, word[31:0], countdown}, and the LFSR tap constant.
- One sub-module: resp_fifo, a parameterised circular FIFO with per-entry countdown plus push/pop/count/head outputs. The RAM array and accept/write logic stay in the top.

Test Plan:
- Write 0xDEADBEEF to 0x10 with wstrb 1111, then read 0x10 -> read data_ok at accept+2 (LATENCY=2), rdata=0xDEADBEEF; store data_ok rdata=0.
- Preload 0x14=0x11223344; write wstrb 0010, wdata 0xABABABAB; read 0x14 -> rdata=0x1122AB44.
- OUTSTANDING=2: hold req for 4 reads -> addr_ok low whenever count==2; data_ok pulses on consecutive cycles in request order with the correct words.
- Accept on the same edge as a head pop -> count stays constant, no data_ok lost or duplicated over 20 back-to-back reads.
- Two reads in flight, 1-cycle rst -> no data_ok afterwards; addr_ok=1 on the first cycle after rst falls.
- With DATA_SRAM_RANDOM_DELAY_EN, 2000 random read/write/strobe transactions against a scoreboard -> all data matches, strict in-order completion, no handshake violations.
